// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Optional parity bit is enabled by defining SEQ_PATTERN_TX_PARITY_EN.
package seq_pattern_pkg;

  // FSM encoding; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_LEN_W      = 4;
  localparam int unsigned DEF_GAP_CYCLES = 1;

  // Extra serial bits appended after the data bits of every frame
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int unsigned PARITY_LEN = 1;
`else
  localparam int unsigned PARITY_LEN = 0;
`endif

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register with zero fill; msb is the bit on the wire.
module seq_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_value,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  // Clear beats load beats shift; zeros fill from the LSB end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sr_q <= '0;
    end else if (clear) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_value;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word + bit count, sends it MSB-first
// on w, then forces GAP_CYCLES idle cycles with w=0.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to each frame.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             w,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SR_W  = WIDTH + PARITY_LEN;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               busy_d, done_d, ready_d;
  logic               sr_clear, sr_load, sr_shift;
  logic [LEN_W-1:0]   len_eff;
  logic [WIDTH-1:0]   data_aligned;
  logic [SR_W-1:0]    sr_load_value;

  // Clamp requested length into 1..WIDTH
  always_comb begin
    len_eff = in_len;
    if (in_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (in_len > LEN_W'(WIDTH)) begin
      len_eff = LEN_W'(WIDTH);
    end
  end

  // Left-align the sent bits so in_data[len-1] lands on the register MSB
  assign data_aligned = in_data << (LEN_W'(WIDTH) - len_eff);

`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic parity;
  // Parity sits directly below the last data bit
  assign parity        = ^data_aligned;
  assign sr_load_value = {data_aligned, 1'b0} | (SR_W'(parity) << (LEN_W'(WIDTH) - len_eff));
`else
  assign sr_load_value = data_aligned;
`endif

  // Next-state, counter and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    sr_clear = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sr_load = 1'b1;
          cnt_d   = LEN_W'(len_eff - LEN_W'(1) + LEN_W'(PARITY_LEN));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_shift = 1'b1;
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        sr_clear = 1'b1;
        cnt_d    = '0;
        gap_d    = '0;
        state_d  = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State, counters and registered handshake/status outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      busy     <= busy_d;
      done     <= done_d;
      in_ready <= ready_d;
    end
  end

  // Serial bit comes straight from the shift register MSB flop
  seq_shift_reg #(
    .WIDTH(SR_W)
  ) u_shift (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear      (sr_clear),
    .load       (sr_load),
    .shift      (sr_shift),
    .load_value (sr_load_value),
    .msb        (w)
  );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP_CYCLES=1 and 0) driven with
// directed and random frames, checked against a frame-timeline model.
module tb_seq_pattern_tx;

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       in_valid [2];
  logic [7:0] in_data  [2];
  logic [3:0] in_len   [2];
  logic       w_o      [2];
  logic       busy_o   [2];
  logic       done_o   [2];
  logic       ready_o  [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: per instance, the timeline of the most recently accepted frame
  bit active [2];
  int c0     [2];
  int nb     [2];
  bit seqb   [2][16];
  bit alt    [2];

  always #5 Clock = ~Clock;

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(1)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid[0]), .in_ready(ready_o[0]),
    .in_data(in_data[0]), .in_len(in_len[0]), .w(w_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_CYCLES(0)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid[1]), .in_ready(ready_o[1]),
    .in_data(in_data[1]), .in_len(in_len[1]), .w(w_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit exp_w(input int i);
    int k = cyc - c0[i];
    if (!active[i] || k >= nb[i]) return 1'b0;
    return seqb[i][k];
  endfunction

  function automatic bit exp_busy(input int i);
    return active[i] && ((cyc - c0[i]) < nb[i] + gap_of(i));
  endfunction

  function automatic bit exp_done(input int i);
    return active[i] && ((cyc - c0[i]) == nb[i]);
  endfunction

  function automatic bit exp_ready(input int i);
    return !active[i] || ((cyc - c0[i]) >= nb[i] + gap_of(i));
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %b, expected %b", tag, cyc, got, exp);
    end
  endtask

  // Record the frame that the coming edge will accept
  task automatic accept(input int i);
    int  len;
    bit  par;
    len = (in_len[i] == 0) ? 1 : ((in_len[i] > 8) ? 8 : int'(in_len[i]));
    par = 1'b0;
    for (int j = 0; j < len; j++) begin
      seqb[i][j] = in_data[i][len-1-j];
      par ^= seqb[i][j];
    end
    if (P == 1) seqb[i][len] = par;
    nb[i]     = len + P;
    c0[i]     = cyc + 1;
    active[i] = 1'b1;
    alt[i]    = ~alt[i];
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w[%0d]", i),     w_o[i],     exp_w(i));
      chk($sformatf("busy[%0d]", i),  busy_o[i],  exp_busy(i));
      chk($sformatf("done[%0d]", i),  done_o[i],  exp_done(i));
      chk($sformatf("ready[%0d]", i), ready_o[i], exp_ready(i));
    end
  endtask

  // Apply current inputs across one clock edge, then check the new cycle
  task automatic cycle();
    for (int i = 0; i < 2; i++) begin
      if (in_valid[i] && exp_ready(i)) accept(i);
    end
    @(posedge Clock);
    @(negedge Clock);
    cyc++;
    check_all();
  endtask

  task automatic offer(input logic [7:0] d, input logic [3:0] l);
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      in_len[i]   = l;
    end
    cycle();
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      in_len[i]   = '0;
      active[i]   = 1'b0;
      c0[i]       = 0;
      nb[i]       = 0;
      alt[i]      = 1'b0;
    end

    // Outputs while held in reset
    @(negedge Clock);
    check_all();
    #2 Reset = 1'b0;
    idle(2);

    // Directed frames: 1101, then length clamps 0 -> 1 bit and 15 -> 8 bits
    offer(8'b0000_1101, 4'd4);
    idle(7);
    offer(8'b1010_0101, 4'd0);
    idle(4);
    offer(8'b1011_0010, 4'd15);
    idle(11);
    offer(8'b0000_0110, 4'd3);
    idle(6);

    // Continuous valid with alternating 1101 / 1011 frames
    for (int k = 0; k < 36; k++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'b1;
        in_data[i]  = alt[i] ? 8'b0000_1011 : 8'b0000_1101;
        in_len[i]   = 4'd4;
      end
      cycle();
    end
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    idle(7);

    // Reset after two bits of an 8-bit frame: frame dropped, no done
    offer(8'b1110_0111, 4'd8);
    cycle();
    #2 Reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_w[%0d]", i),     w_o[i],     1'b0);
      chk($sformatf("rst_busy[%0d]", i),  busy_o[i],  1'b0);
      chk($sformatf("rst_ready[%0d]", i), ready_o[i], 1'b1);
      chk($sformatf("rst_done[%0d]", i),  done_o[i],  1'b0);
      active[i] = 1'b0;
    end
    @(negedge Clock);
    #2 Reset = 1'b0;
    idle(3);
    offer(8'b0101_1001, 4'd6);
    idle(9);

    // Random frames; data/len keep changing after accept
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = 8'($urandom);
        in_len[i]   = 4'($urandom_range(0, 15));
      end
      cycle();
    end
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter that drives the single-bit w stream consumed by the team's Moore sequence detectors.
- Accepts a parallel word and a bit count over a valid/ready handshake, shifts the bits out MSB-first at one bit per Clock, then forces an idle gap with w=0.
- Used as the stimulus source and loopback partner for the detector FSMs, in both behavioural and gate-level variants.

Parameters:
- WIDTH, 8, maximum frame length in bits; width of in_data.
- LEN_W, 4, width of in_len; must satisfy 2**LEN_W > WIDTH.
- GAP_CYCLES, 1, number of forced w=0 cycles after each frame (0 allowed).

Ports:
- Clock  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_len are offered.
- in_ready  output  1  block can accept a frame.
- in_data  input  WIDTH  pattern; bits [in_len-1:0] are sent.
- in_len  input  LEN_W  number of bits to send, 1..WIDTH.
- w  output  1  serial bit stream (registered).
- busy  output  1  frame or gap in progress.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous, active-high) clears everything: state IDLE, w=0, busy=0, done=0, in_ready=1, shift register and counter cleared.
- Reset mid-frame drops the frame; no done pulse is produced for it.
- States:
  - IDLE: in_ready=1, w=0, busy=0.
  - SHIFT: w = current bit, busy=1, in_ready=0.
  - GAP: w=0, busy=1, in_ready=0.
- Accept:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_len is clamped: 0 is treated as 1; values above WIDTH are treated as WIDTH.
  - On that edge, load the shift register and counter, then go to SHIFT.
- Latency:
  - The first bit, in_data[in_len-1], appears on w in the cycle immediately after the accept edge.
  - Each following bit appears one cycle later, in descending order, ending with in_data[0].
- Leaving SHIFT:
  - After the last bit cycle, go to GAP if GAP_CYCLES>0, otherwise to IDLE.
  - GAP lasts exactly GAP_CYCLES cycles, then returns to IDLE.
- done is high for exactly one cycle: the first cycle after the last bit, whether that cycle is GAP or IDLE.
- Frame spacing:
  - No back-to-back acceptance; in_ready is 1 only in IDLE.
  - Minimum spacing between frame starts = in_len + GAP_CYCLES + 1 cycles.
- in_valid while not ready is ignored. in_data/in_len are captured on accept and may change afterwards without effect.
- Counter width is LEN_W; it decrements from in_len-1 to 0 with no wrap-around.
- w is driven from a flop only, so it is glitch-free into the detector.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- With the macro: one extra bit follows in_data[0] on w, equal to the XOR of the sent bits (even parity). done is delayed by one cycle accordingly. Minimum spacing becomes in_len + GAP_CYCLES + 2.
- Without the macro: no parity bit; the timing above applies unchanged.

Decomposition:
- Package seq_pattern_pkg holds:
  - state encoding constants IDLE=2'b00, SHIFT=2'b01, GAP=2'b10 (2'b11 is illegal and recovers to IDLE);
  - default WIDTH, LEN_W, GAP_CYCLES values;
  - the parity-length helper constant.
- One natural sub-module: seq_shift_reg, a loadable left-shift register with asynchronous reset. It outputs its MSB-aligned bit; the top level holds the FSM, counters and handshake.

Test Plan:
- Reset asserted mid-frame (after 2 bits of an 8-bit frame): w=0, busy=0, in_ready=1 immediately, with no done pulse. After release, a new frame is accepted normally.
- in_data=8'b0000_1101, in_len=4, GAP_CYCLES=1:
  - w = 1,1,0,1 on cycles 1–4 after accept; w=0 on cycle 5 with done=1; in_ready=1 on cycle 6.
  - Looped into the Moore detector, z=1 for exactly one cycle after the fourth bit is sampled.
- in_len=0 → exactly one bit in_data[0] is sent. in_len=15 with WIDTH=8 → exactly 8 bits are sent.
- in_valid held high continuously with alternating patterns 1101/1011, len 4: frames start every 6 cycles, and the detector fires only on the 1101 frames.
- GAP_CYCLES=0, 1-bit frames: done is asserted in the IDLE cycle, and the next frame is accepted on the following edge.
- With SEQ_PATTERN_TX_PARITY_EN, pattern 3'b110, in_len=3: w = 1,1,0, then parity 0; done occurs one cycle later than without the macro.
